// File: rtl/cv32e40px_x_result_buffer.sv
// Purpose: in-order coprocessor result FIFO gated by a per-id commit table; optional bypass via `CV32E40PX_X_RESULT_BYPASS_EN.
// Latency: 1 cycle push-to-x_result_valid_o when already committed (0 cycles through the bypass when the macro is defined).
// Backpressure: cpr_ready_o = !full; x_result_valid_o/x_result_o held stable until x_result_ready_i; killed heads drop silently.

package cv32e40px_x_result_pkg;
    parameter int X_ID_WIDTH  = 4;
    parameter int XLEN        = 32;
    parameter int X_RFW_WIDTH = 32;
    parameter int X_RFW_WE    = X_RFW_WIDTH / XLEN;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic [X_RFW_WE-1:0]    we;
        logic [5:0]             ecsdata;
        logic [2:0]             ecswe;
        logic                   exc;
        logic [5:0]             exccode;
        logic                   err;
        logic                   dbg;
    } x_result_t;
endpackage

module cv32e40px_x_result_buffer
    import cv32e40px_x_result_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cpr_valid_i,
    output logic                   cpr_ready_o,
    input  logic [X_ID_WIDTH-1:0]  cpr_id_i,
    input  logic [X_RFW_WIDTH-1:0] cpr_data_i,
    input  logic [4:0]             cpr_rd_i,
    input  logic [X_RFW_WE-1:0]    cpr_we_i,
    input  logic                   cpr_exc_i,
    input  logic [5:0]             cpr_exccode_i,
    input  logic                   x_commit_valid_i,
    input  x_commit_t              x_commit_i,
    output logic                   x_result_valid_o,
    input  logic                   x_result_ready_i,
    output x_result_t              x_result_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int NID = 1 << X_ID_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic [X_RFW_WE-1:0]    we;
        logic                   exc;
        logic [5:0]             exccode;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          in_ent;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;
    logic [NID-1:0]  done;
    logic [NID-1:0]  kill;
    logic            hold;

    logic            empty;
    logic            full;
    logic            fifo_vld;
    logic            fifo_drop;
    logic            pop;
    logic            push;
    logic            res_vld;
    logic            clr;
    logic [X_ID_WIDTH-1:0] clr_id;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rptr];

    always_comb begin
        in_ent         = '0;
        in_ent.id      = cpr_id_i;
        in_ent.data    = cpr_data_i;
        in_ent.rd      = cpr_rd_i;
        in_ent.we      = cpr_we_i;
        in_ent.exc     = cpr_exc_i;
        in_ent.exccode = cpr_exccode_i;
    end

    // Once offered, the head stays offered even if its kill bit is later rewritten.
    assign fifo_vld  = !empty && (hold || (done[head.id] && !kill[head.id]));
    assign fifo_drop = !empty && !hold && done[head.id] && kill[head.id];
    assign pop       = (fifo_vld && x_result_ready_i) || fifo_drop;

`ifdef CV32E40PX_X_RESULT_BYPASS_EN
    logic byp_hit;
    logic byp_vld;
    logic byp_drop;
    logic byp_take;

    assign byp_hit  = empty && cpr_valid_i && done[cpr_id_i];
    assign byp_vld  = byp_hit && !kill[cpr_id_i];
    assign byp_drop = byp_hit && kill[cpr_id_i];
    assign byp_take = byp_vld && x_result_ready_i;
    assign push     = cpr_valid_i && !full && !byp_take && !byp_drop;
    assign res_vld  = fifo_vld || byp_vld;
    assign clr      = empty ? (byp_take || byp_drop) : pop;
    assign clr_id   = empty ? cpr_id_i : head.id;

    always_comb begin
        x_result_o = '0;
        if (!empty || byp_vld) begin
            x_result_o.id      = empty ? in_ent.id      : head.id;
            x_result_o.data    = empty ? in_ent.data    : head.data;
            x_result_o.rd      = empty ? in_ent.rd      : head.rd;
            x_result_o.we      = empty ? in_ent.we      : head.we;
            x_result_o.exc     = empty ? in_ent.exc     : head.exc;
            x_result_o.exccode = empty ? in_ent.exccode : head.exccode;
        end
    end
`else
    assign push    = cpr_valid_i && !full;
    assign res_vld = fifo_vld;
    assign clr     = pop;
    assign clr_id  = head.id;

    always_comb begin
        x_result_o = '0;
        if (!empty) begin
            x_result_o.id      = head.id;
            x_result_o.data    = head.data;
            x_result_o.rd      = head.rd;
            x_result_o.we      = head.we;
            x_result_o.exc     = head.exc;
            x_result_o.exccode = head.exccode;
        end
    end
`endif

    assign cpr_ready_o      = !full;
    assign x_result_valid_o = res_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            done  <= '0;
            kill  <= '0;
            hold  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            hold  <= res_vld && !x_result_ready_i;
            if (clr) done[clr_id] <= 1'b0;
            // Later assignment wins: a same-cycle commit beats the clear.
            if (x_commit_valid_i) begin
                done[x_commit_i.id] <= 1'b1;
                kill[x_commit_i.id] <= x_commit_i.commit_kill;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= in_ent;
    end

endmodule

// File: tb/tb_cv32e40px_x_result_buffer.sv
// Bench for cv32e40px_x_result_buffer (default build): directed scenarios then random traffic against a queue model.
module tb_cv32e40px_x_result_buffer;
    import cv32e40px_x_result_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic                   cpr_valid_i;
    logic                   cpr_ready_o;
    logic [X_ID_WIDTH-1:0]  cpr_id_i;
    logic [X_RFW_WIDTH-1:0] cpr_data_i;
    logic [4:0]             cpr_rd_i;
    logic [X_RFW_WE-1:0]    cpr_we_i;
    logic                   cpr_exc_i;
    logic [5:0]             cpr_exccode_i;
    logic                   x_commit_valid_i;
    x_commit_t              x_commit_i;
    logic                   x_result_valid_o;
    logic                   x_result_ready_i;
    x_result_t              x_result_o;

    always #5 clk = ~clk;

    cv32e40px_x_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cpr_valid_i(cpr_valid_i), .cpr_ready_o(cpr_ready_o), .cpr_id_i(cpr_id_i),
        .cpr_data_i(cpr_data_i), .cpr_rd_i(cpr_rd_i), .cpr_we_i(cpr_we_i),
        .cpr_exc_i(cpr_exc_i), .cpr_exccode_i(cpr_exccode_i),
        .x_commit_valid_i(x_commit_valid_i), .x_commit_i(x_commit_i),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_o(x_result_o)
    );

    typedef struct {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic [X_RFW_WE-1:0]    we;
        logic                   exc;
        logic [5:0]             exccode;
    } ment_t;

    ment_t q[$];
    bit    mdone[16];
    bit    mkill[16];
    int    checks = 0;
    int    passes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic x_result_t exp_res();
        x_result_t r = '0;
        if (q.size() > 0) begin
            r.id = q[0].id; r.data = q[0].data; r.rd = q[0].rd;
            r.we = q[0].we; r.exc = q[0].exc; r.exccode = q[0].exccode;
        end
        return r;
    endfunction

    function automatic bit exp_vld();
        return q.size() > 0 && mdone[q[0].id] && !mkill[q[0].id];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 16; i++) begin mdone[i] = 0; mkill[i] = 0; end
    endtask

    // Advance the reference model by one clock using the inputs seen at the edge.
    task automatic model_update();
        bit    can_push;
        ment_t e;
        can_push = q.size() < DEPTH;
        if (q.size() > 0 && mdone[q[0].id] && (mkill[q[0].id] || x_result_ready_i)) begin
            mdone[q[0].id] = 0;
            void'(q.pop_front());
        end
        if (cpr_valid_i && can_push) begin
            e.id = cpr_id_i; e.data = cpr_data_i; e.rd = cpr_rd_i;
            e.we = cpr_we_i; e.exc = cpr_exc_i; e.exccode = cpr_exccode_i;
            q.push_back(e);
        end
        if (x_commit_valid_i) begin
            mdone[x_commit_i.id] = 1;
            mkill[x_commit_i.id] = x_commit_i.commit_kill;
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        chk({tag, ".ready"}, 64'(cpr_ready_o), 64'(q.size() < DEPTH));
        chk({tag, ".valid"}, 64'(x_result_valid_o), 64'(exp_vld()));
        if (q.size() == 0 || exp_vld())
            chk({tag, ".payload"}, 64'(x_result_o), 64'(exp_res()));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit pv, input int pid, input logic [31:0] pdata,
                         input bit cv, input int cid, input bit ck, input bit rdy);
        cpr_valid_i           = pv;
        cpr_id_i              = X_ID_WIDTH'(pid);
        cpr_data_i            = pdata;
        cpr_rd_i              = 5'($urandom_range(0, 31));
        cpr_we_i              = X_RFW_WE'($urandom_range(0, 1));
        cpr_exc_i             = 1'($urandom_range(0, 1));
        cpr_exccode_i         = 6'($urandom_range(0, 63));
        x_commit_valid_i      = cv;
        x_commit_i.id         = X_ID_WIDTH'(cid);
        x_commit_i.commit_kill = ck;
        x_result_ready_i      = rdy;
    endtask

    function automatic bit in_q(input int id);
        foreach (q[i]) if (q[i].id == X_ID_WIDTH'(id)) return 1;
        return 0;
    endfunction

    initial begin
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst.valid", 64'(x_result_valid_o), 64'd0);
        chk("rst.ready", 64'(cpr_ready_o), 64'd1);
        chk("rst.payload", 64'(x_result_o), 64'd0);
        @(posedge clk); #1 rst_ni = 1'b1;

        // Commit before push: result appears the cycle after the push.
        drive(0, 0, 0, 1, 3, 0, 1); cycle("t1.commit");
        drive(1, 3, 32'hA5, 0, 0, 0, 1); cycle("t1.push");
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        chk("t1.valid", 64'(x_result_valid_o), 64'd1);
        chk("t1.id", 64'(x_result_o.id), 64'd3);
        chk("t1.data", 64'(x_result_o.data), 64'hA5);
        cycle("t1.pop");
        cycle("t1.idle");

        // Out-of-order commits still deliver in push order.
        drive(1, 1, 32'h111, 0, 0, 0, 1); cycle("t2.push1");
        drive(1, 2, 32'h222, 0, 0, 0, 1); cycle("t2.push2");
        drive(0, 0, 0, 1, 2, 0, 1); cycle("t2.commit2");
        drive(0, 0, 0, 1, 1, 0, 1); cycle("t2.commit1");
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        chk("t2.first", 64'(x_result_o.id), 64'd1);
        cycle("t2.pop1"); #1;
        chk("t2.second", 64'(x_result_o.id), 64'd2);
        chk("t2.second_vld", 64'(x_result_valid_o), 64'd1);
        cycle("t2.pop2");
        cycle("t2.idle");

        // Killed entry is dropped without ever being offered.
        drive(1, 5, 32'h55, 0, 0, 0, 1); cycle("t3.push");
        drive(0, 0, 0, 1, 5, 1, 1); cycle("t3.kill");
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("t3.idle");
        chk("t3.count", 64'(dut.count), 64'd0);

        // Full buffer: ready held low through a stalled head until its handshake.
        for (int i = 0; i < 4; i++) begin
            drive(1, 6 + i, 32'h600 + i, 0, 0, 0, 0); cycle("t4.fill");
        end
        drive(1, 10, 32'hA0A, 0, 0, 0, 0); #1;
        chk("t4.full", 64'(cpr_ready_o), 64'd0);
        drive(1, 10, 32'hA0A, 1, 6, 0, 0); cycle("t4.commit");
        drive(1, 10, 32'hA0A, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("t4.stall");
        drive(1, 10, 32'hA0A, 0, 0, 0, 1); #1;
        chk("t4.ready_at_hs", 64'(cpr_ready_o), 64'd0);
        cycle("t4.hs");
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        chk("t4.ready_after", 64'(cpr_ready_o), 64'd1);
        for (int i = 7; i < 11; i++) begin
            drive(i == 7, 10, 32'hA0A, 1, i, 0, 1); cycle("t4.drain");
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle("t4.idle");

        // Mid-transfer reset discards stored and committed results.
        drive(1, 11, 32'hB1, 0, 0, 0, 0); cycle("t5.push");
        drive(1, 12, 32'hB2, 1, 11, 0, 0); cycle("t5.push");
        drive(1, 13, 32'hB3, 1, 12, 0, 0); cycle("t5.push");
        drive(0, 0, 0, 0, 0, 0, 0); cycle("t5.wait"); #1;
        chk("t5.pre_valid", 64'(x_result_valid_o), 64'd1);
        #2 rst_ni = 1'b0; #1;
        chk("t5.rst_valid", 64'(x_result_valid_o), 64'd0);
        chk("t5.rst_ready", 64'(cpr_ready_o), 64'd1);
        model_reset();
        @(posedge clk); #3 rst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("t5.after");
        drive(0, 0, 0, 1, 13, 0, 1); cycle("t5.commit13");
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) cycle("t5.stale");
        chk("t5.count", 64'(dut.count), 64'd0);
        // Clear id 13's leftover commit so random traffic starts clean.
        drive(1, 13, 32'hD13, 0, 0, 0, 1); cycle("t5.flush");
        drive(0, 0, 0, 0, 0, 0, 1); cycle("t5.flush");

        // Random traffic: unique ids in flight, each committed at most once.
        for (int n = 0; n < 400; n++) begin
            bit pv, cv, ck;
            int pid, cid, tries;
            pv = 0; pid = 0; cv = 0; cid = 0; ck = 0;
            if ($urandom_range(0, 99) < 60) begin
                tries = 0;
                pid = $urandom_range(0, 15);
                while ((in_q(pid) || mdone[pid]) && tries < 32) begin
                    pid = $urandom_range(0, 15); tries++;
                end
                pv = !(in_q(pid) || mdone[pid]);
            end
            if (q.size() > 0 && $urandom_range(0, 99) < 50) begin
                int k;
                k = $urandom_range(0, q.size() - 1);
                if (!mdone[q[k].id]) begin
                    cv = 1; cid = q[k].id; ck = ($urandom_range(0, 3) == 0);
                end
            end
            drive(pv, pid, $urandom, cv, cid, ck, $urandom_range(0, 99) < 70);
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
